// File: rtl/sprite_write_arbiter.sv
// Round-robin arbiter sharing the sprite descriptor table write port among NUM_REQ producers.
// Each producer has a one-deep latest-value-wins slot; commits happen only while the table may be written.
module sprite_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 3,
    parameter int BLANK_ONLY = 1,
    parameter int ID_W       = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic                      blank,
    output logic                      wea,
    output logic [ADDR_W-1:0]         addra,
    output logic [DATA_W-1:0]         dina,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic [7:0]                ovw_cnt
);

    localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [DATA_W-1:0]  data_q [NUM_REQ];
    logic [DATA_W-1:0]  data_d [NUM_REQ];
    logic [ADDR_W-1:0]  addr_q [NUM_REQ];
    logic [ADDR_W-1:0]  addr_d [NUM_REQ];
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               wea_q, wea_d;
    logic [ADDR_W-1:0]  addra_q, addra_d;
    logic [DATA_W-1:0]  dina_q, dina_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [7:0]         ovw_cnt_q, ovw_cnt_d;

    logic               commit;
    logic               found;
    logic [ID_W-1:0]    win;
    logic [3:0]         ovw_inc;
    logic [8:0]         ovw_sum;

    // Search upward from rr_ptr, wrapping modulo NUM_REQ (works for non-power-of-2 counts).
    always_comb begin : arb_search
        logic [ID_W:0] idx;
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
            if (idx >= NUM_REQ_W) begin
                idx = idx - NUM_REQ_W;
            end
            if (!found && pend_q[idx[ID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[ID_W-1:0];
            end
        end
    end

    assign commit = found && ((BLANK_ONLY == 0) || blank);

    always_comb begin
        pend_d     = pend_q;
        data_d     = data_q;
        addr_d     = addr_q;
        ovw_inc    = '0;
        rr_ptr_d   = rr_ptr_q;
        wea_d      = commit;
        addra_d    = addra_q;
        dina_d     = dina_q;
        grant_id_d = grant_id_q;

        if (commit) begin
            addra_d       = addr_q[win];
            dina_d        = data_q[win];
            grant_id_d    = win;
            pend_d[win]   = 1'b0;
            rr_ptr_d      = (win == LAST_ID) ? '0 : win + ID_W'(1);
        end

        // A post landing on a slot that is being granted this cycle is a reload, not an overwrite.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if (pend_q[i] && !(commit && win == ID_W'(i))) begin
                    ovw_inc = ovw_inc + 4'd1;
                end
                pend_d[i] = 1'b1;
                data_d[i] = req_data[i*DATA_W +: DATA_W];
                addr_d[i] = req_addr[i*ADDR_W +: ADDR_W];
            end
        end

        ovw_sum   = {1'b0, ovw_cnt_q} + {5'b0, ovw_inc};
        ovw_cnt_d = ovw_sum[8] ? 8'hFF : ovw_sum[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= '0;
            rr_ptr_q   <= '0;
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            grant_id_q <= '0;
            ovw_cnt_q  <= '0;
        end else begin
            pend_q     <= pend_d;
            rr_ptr_q   <= rr_ptr_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            grant_id_q <= grant_id_d;
            ovw_cnt_q  <= ovw_cnt_d;
        end
    end

    // NOTE: slot payloads need no reset; they are only read while their pend flag is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        addr_q <= addr_d;
    end

    assign wea      = wea_q;
    assign addra    = addra_q;
    assign dina     = dina_q;
    assign grant_id = grant_id_q;
    assign busy     = |pend_q;
    assign ovw_cnt  = ovw_cnt_q;

endmodule

// File: tb/tb_sprite_write_arbiter.sv
// Directed bench for sprite_write_arbiter: posts, blank gating, round-robin order, overwrites, reset.
module tb_sprite_write_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [11:0]  req_addr;
    logic         blank;
    logic         wea;
    logic [2:0]   addra;
    logic [31:0]  dina;
    logic [1:0]   grant_id;
    logic         busy;
    logic [7:0]   ovw_cnt;

    int checks   = 0;
    int failures = 0;

    sprite_write_arbiter #(
        .NUM_REQ(4), .DATA_W(32), .ADDR_W(3), .BLANK_ONLY(1), .ID_W(2)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_addr(req_addr), .blank(blank), .wea(wea), .addra(addra), .dina(dina),
        .grant_id(grant_id), .busy(busy), .ovw_cnt(ovw_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input int i, input logic [31:0] d, input logic [2:0] a);
        req_valid[i]        = 1'b1;
        req_data[i*32 +: 32] = d;
        req_addr[i*3 +: 3]   = a;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic check_write(input string tag, input logic [1:0] id,
                               input logic [2:0] a, input logic [31:0] d);
        check({tag, "_wea"}, 32'(wea), 32'd1);
        check({tag, "_id"}, 32'(grant_id), 32'(id));
        check({tag, "_addra"}, 32'(addra), 32'(a));
        check({tag, "_dina"}, dina, d);
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_addr  = '0;
        blank     = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        // Reset state
        check("rst_wea", 32'(wea), 32'd0);
        check("rst_addra", 32'(addra), 32'd0);
        check("rst_dina", dina, 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        check("rst_ovw", 32'(ovw_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single post: wea appears two edges after the post
        blank = 1'b1;
        post(1, 32'h8050_1900, 3'd0);
        cyc();
        req_valid = '0;
        check("single_wea_early", 32'(wea), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        cyc();
        check_write("single", 2'd1, 3'd0, 32'h8050_1900);
        check("single_busy_clr", 32'(busy), 32'd0);
        cyc();
        check("single_wea_pulse", 32'(wea), 32'd0);
        check("single_grant_hold", 32'(grant_id), 32'd1);

        // Round-robin from rr_ptr=0
        pulse_reset();
        for (int i = 0; i < 4; i++) post(i, 32'hA000_0000 + 32'(i), 3'(i));
        cyc();
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check_write("rr0", 2'(i), 3'(i), 32'hA000_0000 + 32'(i));
        end
        cyc();
        check("rr0_idle_wea", 32'(wea), 32'd0);
        check("rr0_idle_busy", 32'(busy), 32'd0);

        // Move rr_ptr to 2 with a lone grant on requester 1, then burst again
        post(1, 32'h0000_1111, 3'd7);
        cyc();
        req_valid = '0;
        cyc();
        check_write("rr_prep", 2'd1, 3'd7, 32'h0000_1111);
        for (int i = 0; i < 4; i++) post(i, 32'hB000_0000 + 32'(i), 3'(i));
        cyc();
        req_valid = '0;
        check("rr2_load_wea", 32'(wea), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check_write("rr2", 2'((k + 2) % 4), 3'((k + 2) % 4), 32'hB000_0000 + 32'((k + 2) % 4));
        end

        // Blank gating
        pulse_reset();
        blank = 1'b0;
        post(0, 32'hC0C0_0000, 3'd5);
        post(3, 32'hC3C3_0003, 3'd6);
        cyc();
        req_valid = '0;
        cyc();
        check("gate_no_wea", 32'(wea), 32'd0);
        check("gate_busy", 32'(busy), 32'd1);
        blank = 1'b1;
        cyc();
        check_write("gate_first", 2'd0, 3'd5, 32'hC0C0_0000);
        blank = 1'b0;
        cyc();
        check("gate_fall_wea", 32'(wea), 32'd0);
        check("gate_fall_busy", 32'(busy), 32'd1);
        check("gate_fall_dina_hold", dina, 32'hC0C0_0000);
        cyc();
        check("gate_wait_wea", 32'(wea), 32'd0);
        blank = 1'b1;
        cyc();
        check_write("gate_second", 2'd3, 3'd6, 32'hC3C3_0003);
        cyc();
        check("gate_done_busy", 32'(busy), 32'd0);

        // Overwrite counting: A, B, C on requester 2, only C committed
        blank = 1'b0;
        post(2, 32'hAAAA_0001, 3'd2);
        cyc();
        post(2, 32'hBBBB_0002, 3'd3);
        cyc();
        post(2, 32'hCCCC_0003, 3'd4);
        cyc();
        req_valid = '0;
        check("ovw_two", 32'(ovw_cnt), 32'd2);
        blank = 1'b1;
        cyc();
        check_write("ovw_latest", 2'd2, 3'd4, 32'hCCCC_0003);
        cyc();
        check("ovw_single_write", 32'(wea), 32'd0);
        check("ovw_busy_clr", 32'(busy), 32'd0);

        // Two requesters overwriting in the same cycle add two
        blank = 1'b0;
        post(0, 32'h0000_0010, 3'd0);
        post(1, 32'h0000_0011, 3'd1);
        cyc();
        post(0, 32'h0000_0020, 3'd0);
        post(1, 32'h0000_0021, 3'd1);
        cyc();
        req_valid = '0;
        check("ovw_dual", 32'(ovw_cnt), 32'd4);

        // Saturation: 4 + 299 overwrites clamps at 255
        for (int n = 0; n < 300; n++) begin
            post(2, 32'(n), 3'd2);
            cyc();
        end
        req_valid = '0;
        check("ovw_sat", 32'(ovw_cnt), 32'd255);
        post(2, 32'hFFFF_0000, 3'd2);
        cyc();
        req_valid = '0;
        check("ovw_sat_hold", 32'(ovw_cnt), 32'd255);

        // Grant-and-reload on requester 0
        pulse_reset();
        check("reload_rst_ovw", 32'(ovw_cnt), 32'd0);
        check("reload_rst_busy", 32'(busy), 32'd0);
        blank = 1'b0;
        post(0, 32'hE0E0_0000, 3'd1);
        cyc();
        blank = 1'b1;
        post(0, 32'hD0D0_0000, 3'd2);
        cyc();
        req_valid = '0;
        check_write("reload_old", 2'd0, 3'd1, 32'hE0E0_0000);
        check("reload_busy", 32'(busy), 32'd1);
        check("reload_ovw", 32'(ovw_cnt), 32'd0);
        cyc();
        check_write("reload_new", 2'd0, 3'd2, 32'hD0D0_0000);
        check("reload_busy_clr", 32'(busy), 32'd0);

        // Reset mid-burst (rr_ptr is 1 here before reset)
        blank = 1'b0;
        post(1, 32'h1111_0001, 3'd1);
        post(2, 32'h2222_0002, 3'd2);
        post(3, 32'h3333_0003, 3'd3);
        cyc();
        req_valid = '0;
        blank = 1'b1;
        cyc();
        check_write("midrst_first", 2'd1, 3'd1, 32'h1111_0001);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("midrst_wea", 32'(wea), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ovw", 32'(ovw_cnt), 32'd0);
        cyc();
        check("midrst_after_wea", 32'(wea), 32'd0);
        post(0, 32'h0F0F_0000, 3'd0);
        post(3, 32'h3F3F_0003, 3'd3);
        cyc();
        req_valid = '0;
        cyc();
        check_write("midrst_rr0", 2'd0, 3'd0, 32'h0F0F_0000);
        cyc();
        check_write("midrst_rr3", 2'd3, 3'd3, 32'h3F3F_0003);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
